// File: rtl/toggle_cover_pkg.sv
`default_nettype none
// toggle_cover_pkg: shared types and helpers for the toggle-cover scheduler.
// Rev 1.0
package toggle_cover_pkg;

  localparam int COVER_TOTAL_DEFAULT = 28338;

  typedef logic [63:0] cover_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cov_out_st_e;

  // Pointer width able to address every bit of a group, never zero.
  function automatic int ptr_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_first_one.sv
`default_nettype none
// rr_first_one: rotating-priority find-first-set; scans ptr, ptr+1, ... with wrap.
// Rev 1.0
module rr_first_one
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int PW    = ptr_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    sel,
  output logic             any
);

  always_comb begin
    int   j;
    logic found;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < WIDTH; i++) begin
      j = int'(ptr) + i;
      if (j >= WIDTH) j = j - WIDTH;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = PW'(j);
      end
    end
    any = found;
  end

endmodule
`default_nettype wire

// File: rtl/toggle_cover_scheduler.sv
`default_nettype none
// toggle_cover_scheduler: buffers toggle hits in a pending bitmap and drains one global index per cycle.
// Rev 1.0 -- define TOGGLE_COVER_DEDUP_EN to report each bit at most once between reset/clear.
module toggle_cover_scheduler
  import toggle_cover_pkg::*;
#(
  parameter int     COVER_WIDTH = 19,
  parameter longint COVER_INDEX = 0,
  parameter longint COVER_TOTAL = COVER_TOTAL_DEFAULT,
  parameter int     CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COVER_WIDTH-1:0] valid,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output cover_idx_t             out_index,
  output logic [CNT_W-1:0]       hit_count,
  output logic                   busy
);

  localparam int PW = ptr_width(COVER_WIDTH);

  cov_out_st_e            state, state_next;
  logic [COVER_WIDTH-1:0] pending, pending_next, set_mask, clr_mask;
  logic [PW-1:0]          ptr, sel;
  logic                   any, load, accept;

`ifdef TOGGLE_COVER_DEDUP_EN
  logic [COVER_WIDTH-1:0] seen;
`endif

  rr_first_one #(
    .WIDTH(COVER_WIDTH),
    .PW   (PW)
  ) u_rr (
    .req(pending),
    .ptr(ptr),
    .sel(sel),
    .any(any)
  );

  assign out_valid = (state == ST_FULL);
  assign busy      = (pending != '0) || out_valid;

  always_comb begin
    accept   = out_valid && out_ready;
    load     = ((state == ST_EMPTY) || out_ready) && any;
    clr_mask = '0;
    if (load) clr_mask[sel] = 1'b1;
    state_next = state;
    if (load) state_next = ST_FULL;
    else if (accept) state_next = ST_EMPTY;
`ifdef TOGGLE_COVER_DEDUP_EN
    // A bit being loaded this cycle counts as seen, so a same-cycle re-hit is dropped.
    set_mask = valid & ~(seen | clr_mask);
`else
    set_mask = valid;
`endif
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_EMPTY;
      pending   <= '0;
      ptr       <= '0;
      out_index <= '0;
      hit_count <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (load) begin
        out_index <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel);
        ptr       <= (sel == PW'(COVER_WIDTH - 1)) ? '0 : sel + 1'b1;
      end
      if (clear) hit_count <= '0;
      else if (accept && !(&hit_count)) hit_count <= hit_count + 1'b1;
    end
  end

`ifdef TOGGLE_COVER_DEDUP_EN
  always_ff @(posedge clock) begin
    if (reset || clear) seen <= '0;
    else seen <= seen | clr_mask;
  end
`endif

`ifndef SYNTHESIS
  logic       prev_stall;
  cover_idx_t prev_index;

  always_ff @(posedge clock) begin
    if (reset) prev_stall <= 1'b0;
    else prev_stall <= out_valid && !out_ready;
    prev_index <= out_index;
    if (!reset) begin
      a_range: assert (COVER_INDEX + longint'(COVER_WIDTH) <= COVER_TOTAL)
        else $error("cover index range exceeds COVER_TOTAL");
      if (prev_stall) begin
        a_hold: assert (out_valid && (out_index == prev_index))
          else $error("output changed while stalled");
      end
    end
  end
`endif

endmodule
`default_nettype wire
